// File: rtl/aes_iter_ctrl_if.sv
// Request/response handshake bundle between a system client and aes_iter_ctrl.
interface aes_iter_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cryptokey;
    logic         busy;

    modport master (
        output in_valid, data_in, key, out_ready,
        input  in_ready, out_valid, cryptokey, busy
    );

    modport slave (
        input  in_valid, data_in, key, out_ready,
        output in_ready, out_valid, cryptokey, busy
    );
endinterface

// File: rtl/aes_iter_ctrl.sv
// Sequencer for a one-round-per-clock AES-128 datapath: owns state/round-key registers,
// steps the external round unit through NR rounds and holds the result under backpressure.
module aes_iter_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    aes_iter_ctrl_if.slave       bus_if,
    output logic [127:0]         o_dp_st,
    output logic [127:0]         o_dp_rk,
    output logic [7:0]           o_dp_rcon,
    output logic                 o_dp_last,
    output logic [3:0]           o_dp_round,
    input  logic [127:0]         i_dp_rk_next,
    input  logic [127:0]         i_dp_st_next
);
    localparam logic [3:0] LastRound = 4'(NR);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       r_state;
    state_e       w_state_nxt;
    logic [127:0] r_st;
    logic [127:0] w_st_nxt;
    logic [127:0] r_rk;
    logic [127:0] w_rk_nxt;
    logic [7:0]   r_rcon;
    logic [7:0]   w_rcon_nxt;
    logic [3:0]   r_round;
    logic [3:0]   w_round_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_st    <= '0;
            r_rk    <= '0;
            r_rcon  <= '0;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_rk    <= w_rk_nxt;
            r_rcon  <= w_rcon_nxt;
            r_round <= w_round_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_rk_nxt    = r_rk;
        w_rcon_nxt  = r_rcon;
        w_round_nxt = r_round;
        case (r_state)
            StIdle: begin
                if (bus_if.in_valid) begin
                    w_st_nxt    = bus_if.data_in ^ bus_if.key;
                    w_rk_nxt    = bus_if.key;
                    w_round_nxt = 4'd1;
                    w_rcon_nxt  = 8'h01;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                w_st_nxt   = i_dp_st_next;
                w_rk_nxt   = i_dp_rk_next;
                w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                if (r_round == LastRound) begin
                    w_round_nxt = '0;
                    w_state_nxt = StDone;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            // State frozen until the consumer takes the ciphertext.
            StDone: begin
                if (bus_if.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus_if.in_ready  = (r_state == StIdle);
    assign bus_if.out_valid = (r_state == StDone);
    assign bus_if.busy      = (r_state != StIdle);
    assign bus_if.cryptokey = r_st;

    assign o_dp_st    = r_st;
    assign o_dp_rk    = r_rk;
    assign o_dp_rcon  = r_rcon;
    assign o_dp_round = r_round;
    assign o_dp_last  = (r_state == StRun) && (r_round == LastRound);
endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Randomized scoreboard bench for aes_iter_ctrl with a behavioural AES-128 round unit
// attached and a whole-block reference encryption model.
module tb_aes_iter_ctrl;
    localparam int NR_TB = 10;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_iter_ctrl_if bus ();
    logic [127:0] dp_st, dp_rk, dp_rk_next, dp_st_next;
    logic [7:0]   dp_rcon;
    logic         dp_last;
    logic [3:0]   dp_round;

    aes_iter_ctrl #(.NR(10)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus_if       (bus),
        .o_dp_st      (dp_st),
        .o_dp_rk      (dp_rk),
        .o_dp_rcon    (dp_rcon),
        .o_dp_last    (dp_last),
        .o_dp_round   (dp_round),
        .i_dp_rk_next (dp_rk_next),
        .i_dp_st_next (dp_st_next)
    );

    logic [7:0] sbox_t [256];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv, p;
        inv = 8'h01;
        p   = v;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, p);
            p = gmul(p, p);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]}
             ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] c0, c1, c2, c3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
                b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
                b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
                b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i] ^ k[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s, rk;
        s  = pt ^ k;
        rk = k;
        for (int r = 0; r < 10; r++) begin
            rk = key_expand(rk, RCON[r]);
            s  = aes_round(s, rk, r == 9);
        end
        return s;
    endfunction

    initial for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));

    assign dp_rk_next = key_expand(dp_rk, dp_rcon);
    assign dp_st_next = aes_round(dp_st, dp_rk_next, dp_last);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    bit ready_rand = 1'b0;
    bit ready_val  = 1'b1;
    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Scoreboard monitor: accepts push the model result, handshakes pop and compare.
    logic [127:0] exp_q [$];
    logic [127:0] ct_hist [$];
    bit active = 1'b0;
    int acc_cyc = 0, prev_acc = 0, acc_cnt = 0, hs_cnt = 0, hs_cyc = 0, mon_i = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
            exp_q.delete();
        end else begin
            if (active) begin
                mon_i = cyc - acc_cyc;
                chk("busy_active", 128'(bus.busy), 128'(1));
                chk("in_ready_active", 128'(bus.in_ready), 128'(0));
                if (mon_i <= NR_TB) begin
                    chk("dp_round", 128'(dp_round), 128'(mon_i));
                    chk("dp_rcon", 128'(dp_rcon), 128'(RCON[mon_i-1]));
                    chk("dp_last", 128'(dp_last), 128'(mon_i == NR_TB));
                    chk("out_valid_run", 128'(bus.out_valid), 128'(0));
                end else begin
                    chk("out_valid_done", 128'(bus.out_valid), 128'(1));
                    chk("dp_round_done", 128'(dp_round), 128'(0));
                    chk("dp_last_done", 128'(dp_last), 128'(0));
                    chk("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) chk("cryptokey", bus.cryptokey, exp_q[0]);
                    if (bus.out_ready) begin
                        ct_hist.push_back(bus.cryptokey);
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        hs_cnt++;
                        hs_cyc = cyc;
                        active = 1'b0;
                    end
                end
            end else begin
                chk("in_ready_idle", 128'(bus.in_ready), 128'(1));
                chk("busy_idle", 128'(bus.busy), 128'(0));
                chk("out_valid_idle", 128'(bus.out_valid), 128'(0));
                chk("dp_round_idle", 128'(dp_round), 128'(0));
                chk("dp_last_idle", 128'(dp_last), 128'(0));
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(aes_ref(bus.data_in, bus.key));
                prev_acc = acc_cyc;
                acc_cyc  = cyc;
                acc_cnt++;
                active = 1'b1;
            end
        end
    end

    task automatic send(input logic [127:0] pt, input logic [127:0] k, input bit hold);
        int n;
        n = 0;
        bus.data_in  = pt;
        bus.key      = k;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 400);
        chk("accept_timeout", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("handshake_timeout", 128'(hs_cnt >= target), 128'(1));
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk_b;
        int n, n0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.key      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_cryptokey", bus.cryptokey, 128'(0));
        chk("rst_dp_rk", dp_rk, 128'(0));
        chk("rst_dp_rcon", 128'(dp_rcon), 128'(0));
        chk("rst_dp_round", 128'(dp_round), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 C.1 single block
        send(C1_PT, C1_KEY, 1'b0);
        wait_hs(1);
        chk("c1_kat", ct_hist[0], C1_CT);

        // Back-to-back with in_valid held high
        send(C1_PT, C1_KEY, 1'b1);
        send('0, '0, 1'b0);
        chk("b2b_gap", 128'(acc_cyc - prev_acc), 128'(12));
        wait_hs(3);
        chk("b2b_first", ct_hist[1], C1_CT);
        chk("b2b_zero_kat", ct_hist[2], Z_CT);

        // Backpressure with a second request waiting
        ready_val = 1'b0;
        send(C1_PT, C1_KEY, 1'b0);
        blk_b = rand128();
        bus.data_in  = blk_b;
        bus.key      = rand128();
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        repeat (7) begin
            @(negedge clk);
            chk("bp_cryptokey", bus.cryptokey, C1_CT);
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
        end
        ready_val = 1'b1;
        n0 = acc_cnt;
        n = 0;
        while (acc_cnt == n0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus.in_valid = 1'b0;
        chk("bp_accept_after_hs", 128'(acc_cyc - hs_cyc), 128'(1));
        wait_hs(5);
        chk("bp_first", ct_hist[3], C1_CT);

        // Reset during round 5
        send(C1_PT, C1_KEY, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_round", 128'(dp_round), 128'(5));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("mid_rst_dp_st", dp_st, 128'(0));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        send(C1_PT, C1_KEY, 1'b0);
        wait_hs(6);
        chk("post_rst_kat", ct_hist[5], C1_CT);

        // Inputs wiggled while running must not disturb the result
        send(C1_PT, C1_KEY, 1'b0);
        repeat (8) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.data_in  = rand128();
            bus.key      = rand128();
        end
        bus.in_valid = 1'b0;
        wait_hs(7);
        chk("ignored_inputs_kat", ct_hist[6], C1_CT);

        // Random blocks with random gaps and random backpressure
        ready_rand = 1'b1;
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(rand128(), (k % 5 == 0) ? 128'(0) : rand128(), 1'b0);
        end
        wait_hs(7 + 16);
        ready_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_iter_ctrl.md
# aes_iter_ctrl

Sequencing controller for an iterative AES-128 encryption datapath that computes one round per clock. It accepts a plaintext/key pair on a valid/ready handshake and owns the state and round-key registers. It steps an external combinational round/key-expansion unit through NR rounds, generating the round index, round constant and last-round flag. It then presents the ciphertext on a valid/ready output with backpressure. It sits between the system request interface and the round logic, replacing the free-running top-level sequencing.

## Interface
- NR, 10, number of rounds; only 10 is supported for AES-128.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request: data_in/key valid
- in_ready  out  1  controller can accept a request
- data_in  in  128  plaintext, byte 0 in [127:120]
- key  in  128  cipher key, same byte order
- out_valid  out  1  cryptokey holds a finished ciphertext
- out_ready  in  1  consumer accepts the ciphertext
- cryptokey  out  128  ciphertext, equal to dp_st
- busy  out  1  high in RUN or DONE
- dp_st  out  128  state register to the datapath
- dp_rk  out  128  round-key register to the datapath
- dp_rcon  out  8  round constant for the current key-expansion step
- dp_last  out  1  current round is the final one (no MixColumns)
- dp_round  out  4  current round index, 1..NR in RUN, 0 otherwise
- dp_rk_next  in  128  datapath: KeyExpand(dp_rk, dp_rcon)
- dp_st_next  in  128  datapath: Round(dp_st, dp_rk_next, dp_last)

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: dp_st<=data_in^key, dp_rk<=key, dp_round<=1, dp_rcon<=8'h01, go to RUN.
- RUN: each cycle dp_st<=dp_st_next, dp_rk<=dp_rk_next, dp_rcon<=xtime(dp_rcon), dp_round<=dp_round+1.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- dp_last = (state==RUN) && (dp_round==NR). This is combinational from registers.
- Leaving RUN: on the cycle with dp_round==NR, the registers update as above, then dp_round<=0, state<=DONE, out_valid<=1.
- DONE:
  - dp_st, and therefore cryptokey, is frozen. out_valid=1.
  - On out_ready: out_valid<=0, state<=IDLE.
  - dp_rk and dp_rcon are don't-care but must hold.
- in_valid outside IDLE is ignored. in_ready=0 in RUN and DONE. data_in and key are sampled only at the accept edge.
- out_ready outside DONE is ignored.
- busy = (state != IDLE).

## Timing
- Accept edge E0: in_valid && in_ready sampled high.
- Rounds 1..NR execute at edges E1..E10. out_valid is high from just after E10, so latency is NR cycles from the accept edge.
- Output handshake completes at the first edge with out_valid && out_ready. in_ready is high the following cycle.
- Minimum request period is NR+2 = 12 cycles with out_ready tied high.
- Backpressure: while out_valid && !out_ready, cryptokey and out_valid are stable for any number of cycles.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, cryptokey=dp_st=0, dp_rk=0, dp_rcon=0, dp_round=0, dp_last=0.
- Reset asserted mid-RUN or in DONE: all registers clear immediately and asynchronously. The in-flight result is discarded and no out_valid pulse appears. After deassertion, the first accept may occur at the next edge.
- All outputs are registered or derived only from registered state. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- FIPS-197 C.1 vector, with golden combinational round/key-expansion datapath attached:
  - Stimulus: data_in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, out_ready=1.
  - Required: cryptokey=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid rising exactly 10 cycles after the accept edge, and busy high throughout.
- Control trace on the same run:
  - dp_rcon per RUN cycle = 01,02,04,08,10,20,40,80,1b,36.
  - dp_round = 1..10.
  - dp_last high only on the cycle with dp_round=10.
- Backpressure:
  - Stimulus: out_ready=0 for 7 cycles after out_valid, and in_valid=1 with a different block during that time.
  - Required: cryptokey stable, in_ready=0, the second block is not accepted until the cycle after the out handshake.
- Back-to-back:
  - Stimulus: in_valid held high, out_ready=1, two vectors (C.1 and all-zero plaintext with all-zero key).
  - Required: second result 66e94bd4ef8a2c3b884cfa59ca342b2e, with accepts exactly 12 cycles apart.
- Reset mid-operation:
  - Stimulus: reset low during round 5.
  - Required: out_valid=0, busy=0, in_ready=1, dp_st=0 immediately. No out_valid pulse follows.
  - After reset release, a new C.1 request completes correctly.
- Ignored inputs:
  - Stimulus: toggle data_in/key and pulse in_valid during RUN.
  - Required: result unchanged (69c4e0d8…).
